// File: rtl/frogger_pkg.sv
// Shared constants for the Frogger game: grid geometry, spawn point,
// lily pad layout, scoring/lives limits, FSM encodings and tile codes.
package frogger_pkg;

    // Playfield geometry and respawn tile (bottom grass row)
    localparam int C_GAME_WIDTH   = 14;
    localparam int C_GAME_HEIGHT  = 13;
    localparam int C_START_X      = 6;
    localparam int C_START_Y      = 12;

    // Bit n set means column n of row 0 is a lily pad
    localparam logic [C_GAME_WIDTH-1:0] C_LILY_MASK = 14'b10010010010010;

    localparam int C_SCORE_LIMIT  = 99;
    localparam int C_INIT_LIVES   = 3;
    localparam int C_DEATH_FRAMES = 60;

    // Datapath widths
    localparam int POS_W       = 6;
    localparam int LIVES_W     = 2;
    localparam int SCORE_W     = 7;
    localparam int STATE_W     = 3;
    localparam int FRAME_CNT_W = $clog2(C_DEATH_FRAMES);

    // Game FSM encodings; these values are visible on the state output
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUNNING   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DYING     = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd3;
    localparam logic [STATE_W-1:0] ST_CLEANUP   = 3'd4;

    // Tile classes shared with the renderer and collision logic
    typedef enum logic [2:0] {
        TILE_WALL  = 3'd0,
        TILE_ROAD  = 3'd1,
        TILE_WATER = 3'd2,
        TILE_SAFE  = 3'd3,
        TILE_LILY  = 3'd4
    } tile_e;

    // True when column col of the top row holds a lily pad. The mask is
    // zero-extended so that any 6-bit column index is in range.
    function automatic logic is_lily(input logic [POS_W-1:0] col);
        logic [63:0] mask;
        mask = 64'(C_LILY_MASK);
        return mask[col];
    endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// Bundle between the game sequencer and its environment: per-frame tick,
// debounced buttons and collision flag in; frog position, lives, score,
// state and event pulses out.
interface frogger_game_ctrl_if;
    import frogger_pkg::*;

    logic               frame_tick;
    logic               game_start;
    logic               up_mvt;
    logic               down_mvt;
    logic               left_mvt;
    logic               right_mvt;
    logic               collided;

    logic [POS_W-1:0]   frog_x;
    logic [POS_W-1:0]   frog_y;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [STATE_W-1:0] state;
    logic               game_active;
    logic               death_pulse;
    logic               score_pulse;
    logic               win;

    // Environment side: drives buttons/tick/collision, observes the game
    modport master (
        output frame_tick, game_start, up_mvt, down_mvt, left_mvt, right_mvt, collided,
        input  frog_x, frog_y, lives, score, state,
               game_active, death_pulse, score_pulse, win
    );

    // Game sequencer side
    modport slave (
        input  frame_tick, game_start, up_mvt, down_mvt, left_mvt, right_mvt, collided,
        output frog_x, frog_y, lives, score, state,
               game_active, death_pulse, score_pulse, win
    );

endinterface

// File: rtl/frogger_pos_ctrl.sv
// Frog tile position register. Computes the clamped candidate position for
// the current move pulses (Up > Down > Left > Right) and commits it unless
// frozen; load_start overrides everything and returns the frog to spawn.
module frogger_pos_ctrl
    import frogger_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             freeze,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic [POS_W-1:0] nxt_x,
    output logic [POS_W-1:0] nxt_y
);

    localparam logic [POS_W-1:0] X_MAX   = POS_W'(C_GAME_WIDTH - 1);
    localparam logic [POS_W-1:0] Y_MAX   = POS_W'(C_GAME_HEIGHT - 1);
    localparam logic [POS_W-1:0] X_START = POS_W'(C_START_X);
    localparam logic [POS_W-1:0] Y_START = POS_W'(C_START_Y);
    localparam logic [POS_W-1:0] ONE     = POS_W'(1);

    // Candidate position: one move at most, saturating at the grid edges.
    // The sequencer inspects this to resolve landings on the top row.
    always_comb begin
        nxt_x = x;
        nxt_y = y;
        if (up) begin
            if (y != '0) nxt_y = y - ONE;
        end else if (down) begin
            if (y != Y_MAX) nxt_y = y + ONE;
        end else if (left) begin
            if (x != '0) nxt_x = x - ONE;
        end else if (right) begin
            if (x != X_MAX) nxt_x = x + ONE;
        end
    end

    // Position register: spawn on reset/load, hold while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= X_START;
            y <= Y_START;
        end else if (load_start) begin
            x <= X_START;
            y <= Y_START;
        end else if (!freeze) begin
            x <= nxt_x;
            y <= nxt_y;
        end
    end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Central Frogger game sequencer: game FSM, lives, score and the death
// timer. Frog position lives in frogger_pos_ctrl; this block decides when
// it may move, when it respawns and when it is frozen.
module frogger_game_ctrl
    import frogger_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    frogger_game_ctrl_if.slave  bus
);

    localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(C_INIT_LIVES);
    localparam logic [SCORE_W-1:0]     SCORE_LAST = SCORE_W'(C_SCORE_LIMIT - 1);
    localparam logic [SCORE_W-1:0]     SCORE_MAX  = SCORE_W'(C_SCORE_LIMIT);
    localparam logic [FRAME_CNT_W-1:0] CNT_LAST   = FRAME_CNT_W'(C_DEATH_FRAMES - 1);

    logic [STATE_W-1:0]     state, state_nxt;
    logic [LIVES_W-1:0]     lives;
    logic [SCORE_W-1:0]     score;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   death_pulse, score_pulse, win, game_active;

    logic                   load_start, freeze;
    logic                   death, scored, win_set;
    logic                   any_mvt;
    logic [POS_W-1:0]       x, y, nxt_x, nxt_y;

    assign any_mvt = bus.up_mvt | bus.down_mvt | bus.left_mvt | bus.right_mvt;

    frogger_pos_ctrl u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .freeze     (freeze),
        .up         (bus.up_mvt),
        .down       (bus.down_mvt),
        .left       (bus.left_mvt),
        .right      (bus.right_mvt),
        .x          (x),
        .y          (y),
        .nxt_x      (nxt_x),
        .nxt_y      (nxt_y)
    );

    // Next-state and event decode. A collision outranks any move; a move
    // into the top row is resolved immediately as either a score (lily)
    // or a drowning. On a drowning the move is discarded, exactly as for
    // a collision, so the frog stays on the tile it jumped from.
    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        freeze     = 1'b1;
        death      = 1'b0;
        scored     = 1'b0;
        win_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.game_start) state_nxt = ST_CLEANUP;
            end
            ST_CLEANUP: begin
                load_start = 1'b1;
                state_nxt  = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (bus.collided) begin
                    death     = 1'b1;
                    state_nxt = ST_DYING;
                end else if (any_mvt) begin
                    if (nxt_y == '0) begin
                        if (is_lily(nxt_x)) begin
                            scored     = 1'b1;
                            load_start = 1'b1;
                            if (score == SCORE_LAST) begin
                                win_set   = 1'b1;
                                state_nxt = ST_GAME_OVER;
                            end
                        end else begin
                            death     = 1'b1;
                            state_nxt = ST_DYING;
                        end
                    end else begin
                        freeze = 1'b0;
                    end
                end
            end
            ST_DYING: begin
                if (bus.frame_tick && frame_cnt == CNT_LAST) begin
                    if (lives == '0) begin
                        state_nxt = ST_GAME_OVER;
                    end else begin
                        load_start = 1'b1;
                        state_nxt  = ST_RUNNING;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (bus.game_start) state_nxt = ST_CLEANUP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state plus the registered status flags derived from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            game_active <= 1'b0;
            death_pulse <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            game_active <= (state_nxt == ST_RUNNING);
            death_pulse <= death;
            score_pulse <= scored;
        end
    end

    // Lives: refilled at game start, one lost per death, never below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lives <= LIVES_INIT;
        end else if (state == ST_CLEANUP) begin
            lives <= LIVES_INIT;
        end else if (death && lives != '0) begin
            lives <= lives - LIVES_W'(1);
        end
    end

    // Score and win flag: cleared at game start, score saturates at limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
            win   <= 1'b0;
        end else if (state == ST_CLEANUP) begin
            score <= '0;
            win   <= 1'b0;
        end else begin
            if (scored && score < SCORE_MAX) score <= score + SCORE_W'(1);
            if (win_set) win <= 1'b1;
        end
    end

    // Death timer: restarts on each death, counts frame ticks while dying
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (death) begin
            frame_cnt <= '0;
        end else if (state == ST_DYING && bus.frame_tick) begin
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign bus.frog_x      = x;
    assign bus.frog_y      = y;
    assign bus.lives       = lives;
    assign bus.score       = score;
    assign bus.state       = state;
    assign bus.game_active = game_active;
    assign bus.death_pulse = death_pulse;
    assign bus.score_pulse = score_pulse;
    assign bus.win         = win;

endmodule
